// File: rtl/sl2_apb_pkg.sv
// -----------------------------------------------------------------------------
// sl2_apb_pkg
// Shared definitions for the SL2 APB master path: the master FSM state type,
// default bus widths and the register map of the bridge register slave.
// Optional feature macro used by apb_master_arbiter: APB_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
package sl2_apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_arb_state_t;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   // Bridge register slave map
   localparam logic [APB_ADDR_W-1:0] DATA_ADDR   = 32'h0000_0003;
   localparam logic [APB_ADDR_W-1:0] CONFIG_ADDR = 32'h0000_0004;

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter_2.sv
// -----------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin arbiter. The grant is combinational from req_valid and
// the registered last_grant; last_grant updates only when the grant is taken.
// Ports:
//   clock, reset   : system clock, synchronous active-high reset
//   req_valid[1:0] : requests
//   accept         : the current grant is being consumed this cycle
//   grant[1:0]     : one-hot grant (zero when nobody requests)
// -----------------------------------------------------------------------------
module rr_arbiter_2 (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req_valid,
   input  logic       accept,
   output logic [1:0] grant
);

   logic last_grant_q, last_grant_d;

   always_comb begin
      grant = 2'b00;
      unique case (req_valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         // On contention favour whoever was not served last
         2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (accept && (grant != 2'b00)) last_grant_d = grant[1];
   end

   // Resets to 1 so requester 0 wins the first contention
   always_ff @(posedge clock) begin
      if (reset) last_grant_q <= 1'b1;
      else       last_grant_q <= last_grant_d;
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
// Shares one APB bus between requester 0 (SL2 link engine) and requester 1
// (host sequencer). Single-beat commands are arbitrated round-robin, run
// through APB SETUP/ACCESS, and the response is returned as a one-cycle
// rsp_valid pulse to the owner.
// Optional feature: define APB_ARB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES cycles without pready (response carries rsp_err=1).
// Ports:
//   clock, reset                       : system clock, sync active-high reset
//   req_valid/ready/write/addr/wdata/strb : per-requester command channel
//   rsp_valid, rsp_rdata, rsp_err      : response (rdata/err shared)
//   paddr/psel/penable/pwrite/pwdata/pstrb/pready/prdata/pslverr : APB
// -----------------------------------------------------------------------------
module apb_master_arbiter
   import sl2_apb_pkg::*;
#(
   parameter int ADDR_W         = APB_ADDR_W,
   parameter int DATA_W         = APB_DATA_W,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [1:0]              req_write,
   input  logic [2*ADDR_W-1:0]     req_addr,
   input  logic [2*DATA_W-1:0]     req_wdata,
   input  logic [2*(DATA_W/8)-1:0] req_strb,
   output logic [1:0]              rsp_valid,
   output logic [DATA_W-1:0]       rsp_rdata,
   output logic                    rsp_err,
   output logic [ADDR_W-1:0]       paddr,
   output logic                    psel,
   output logic                    penable,
   output logic                    pwrite,
   output logic [DATA_W-1:0]       pwdata,
   output logic [DATA_W/8-1:0]     pstrb,
   input  logic                    pready,
   input  logic [DATA_W-1:0]       prdata,
   input  logic                    pslverr
);

   localparam int STRB_W = DATA_W / 8;

   apb_arb_state_t    state_q,   state_d;
   logic              owner_q,   owner_d;
   logic [ADDR_W-1:0] paddr_q,   paddr_d;
   logic              psel_q,    psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q,  pwrite_d;
   logic [DATA_W-1:0] pwdata_q,  pwdata_d;
   logic [STRB_W-1:0] pstrb_q,   pstrb_d;
   logic [1:0]        rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q,   rsp_err_d;

   logic [1:0] grant;
   logic       accept;
   logic       gidx;

`ifdef APB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

   assign accept = (state_q == IDLE) && (grant != 2'b00) && !reset;
   assign gidx   = grant[1];

   rr_arbiter_2 u_arb (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .accept    (accept),
      .grant     (grant)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      paddr_d     = paddr_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      pstrb_d     = pstrb_q;
      rsp_valid_d = 2'b00;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef APB_ARB_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               owner_d  = gidx;
               pwrite_d = req_write[gidx];
               paddr_d  = req_addr[gidx*ADDR_W +: ADDR_W];
               // Reads drive zero data and strobes on the bus
               pwdata_d = req_write[gidx] ? req_wdata[gidx*DATA_W +: DATA_W] : '0;
               pstrb_d  = req_write[gidx] ? req_strb[gidx*STRB_W +: STRB_W]  : '0;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
            to_cnt_d  = '0;
`endif
         end
         ACCESS: begin
            if (pready) begin
               psel_d               = 1'b0;
               penable_d            = 1'b0;
               state_d              = IDLE;
               rsp_valid_d[owner_q] = 1'b1;
               rsp_rdata_d          = pwrite_q ? '0 : prdata;
               rsp_err_d            = pslverr;
            end
`ifdef APB_ARB_TIMEOUT_EN
            // pready is checked first so it wins on the terminal count
            else if (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               psel_d               = 1'b0;
               penable_d            = 1'b0;
               state_d              = IDLE;
               rsp_valid_d[owner_q] = 1'b1;
               rsp_rdata_d          = '0;
               rsp_err_d            = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         paddr_q     <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         rsp_valid_q <= 2'b00;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
         to_cnt_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         paddr_q     <= paddr_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
`ifdef APB_ARB_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
`endif
      end
   end

   // req_ready is the accept handshake itself, so it must be visible in the
   // same IDLE cycle the command is taken; everything else is a flop.
   assign req_ready = accept ? grant : 2'b00;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign paddr     = paddr_q;
   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign pwdata    = pwdata_q;
   assign pstrb     = pstrb_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;
   import sl2_apb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 4;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [1:0]       req_valid = '0;
   logic [1:0]       req_ready;
   logic [1:0]       req_write = '0;
   logic [2*AW-1:0]  req_addr  = '0;
   logic [2*DW-1:0]  req_wdata = '0;
   logic [2*SW-1:0]  req_strb  = '0;
   logic [1:0]       rsp_valid;
   logic [DW-1:0]    rsp_rdata;
   logic             rsp_err;
   logic [AW-1:0]    paddr;
   logic             psel, penable, pwrite;
   logic [DW-1:0]    pwdata;
   logic [SW-1:0]    pstrb;
   logic             pready  = 1'b0;
   logic [DW-1:0]    prdata  = '0;
   logic             pslverr = 1'b0;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: who was served last, and last response seen
   bit            last_g    = 1'b1;
   logic [DW-1:0] prev_rd   = '0;
   logic          prev_err  = 1'b0;

   apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
      .pslverr(pslverr)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input bit v0, input bit v1);
      if (v0 && v1) return last_g ? 0 : 1;
      return v0 ? 0 : 1;
   endfunction

   // One complete transfer, entered and left at a negedge with the DUT idle.
   task automatic xfer(input bit v0, input bit v1, input bit wr0, input bit wr1,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                       input int waits, input logic [DW-1:0] rd, input bit err,
                       output int g);
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic [SW-1:0] es;
      bit            ew;
      req_valid = {v1, v0};
      req_write = {wr1, wr0};
      req_addr  = {a1, a0};
      req_wdata = {d1, d0};
      req_strb  = {s1, s0};
      #1;
      g = pick(v0, v1);
      chk("req_ready", 64'(req_ready), 64'(2'b01 << g));
      last_g = g[0];
      ew = g ? wr1 : wr0;
      ea = g ? a1 : a0;
      ed = ew ? (g ? d1 : d0) : '0;
      es = ew ? (g ? s1 : s0) : '0;
      @(posedge clock); @(negedge clock);
      req_valid[g] = 1'b0;
      #1;
      chk("setup_psel",    64'(psel),    1);
      chk("setup_penable", 64'(penable), 0);
      chk("setup_paddr",   64'(paddr),   64'(ea));
      chk("setup_pwrite",  64'(pwrite),  64'(ew));
      chk("setup_pwdata",  64'(pwdata),  64'(ed));
      chk("setup_pstrb",   64'(pstrb),   64'(es));
      chk("setup_ready",   64'(req_ready), 0);
      chk("hold_rdata",    64'(rsp_rdata), 64'(prev_rd));
      chk("hold_err",      64'(rsp_err),   64'(prev_err));
      @(posedge clock);
      for (int w = 0; w <= waits; w++) begin
         @(negedge clock);
         pready  = (w == waits);
         prdata  = (w == waits) ? rd  : $urandom;
         pslverr = (w == waits) ? err : 1'($urandom);
         chk("acc_psel",    64'(psel),      1);
         chk("acc_penable", 64'(penable),   1);
         chk("acc_paddr",   64'(paddr),     64'(ea));
         chk("acc_pwdata",  64'(pwdata),    64'(ed));
         chk("acc_pstrb",   64'(pstrb),     64'(es));
         chk("acc_rspv",    64'(rsp_valid), 0);
         @(posedge clock);
      end
      @(negedge clock);
      pready = 1'b0; pslverr = 1'b0;
      prev_rd  = ew ? '0 : rd;
      prev_err = err;
      chk("rsp_valid", 64'(rsp_valid), 64'(2'b01 << g));
      chk("rsp_rdata", 64'(rsp_rdata), 64'(prev_rd));
      chk("rsp_err",   64'(rsp_err),   64'(prev_err));
      chk("end_psel",  64'(psel | penable), 0);
   endtask

   initial begin
      int g;
      int exp_order[4] = '{0, 1, 0, 1};

      // Reset: requests present but nothing may be granted or driven
      req_valid = 2'b11;
      repeat (3) @(negedge clock);
      #1;
      chk("rst_ready", 64'(req_ready), 0);
      chk("rst_bus",   64'({psel, penable, pwrite}), 0);
      chk("rst_paddr", 64'(paddr), 0);
      chk("rst_wdata", 64'({pwdata, pstrb}), 0);
      chk("rst_rsp",   64'({rsp_valid, rsp_err}), 0);
      chk("rst_rdata", 64'(rsp_rdata), 0);
      req_valid = 2'b00;
      reset = 1'b0;
      @(negedge clock);

      // Single write, zero wait states
      xfer(1, 0, 1, 0, DATA_ADDR, '0, 32'hA5A5_0001, '0, 4'hF, '0, 0, 32'hDEAD_BEEF, 0, g);
      // Read from requester 1 with two wait states
      xfer(0, 1, 0, 0, '0, DATA_ADDR, '0, 32'h1111_2222, '0, 4'hF, 2, 32'h1234_5678, 0, g);

      // Contention: grant alternates starting with requester 0
      for (int i = 0; i < 4; i++) begin
         xfer(1, 1, 1'(i), 1'(~i), CONFIG_ADDR, DATA_ADDR, $urandom, $urandom,
              4'h3, 4'hC, i % 2, $urandom, 0, g);
         chk("cont_order", 64'(g), 64'(exp_order[i]));
      end

      // Slave error, then a clean transfer
      xfer(1, 0, 1, 0, CONFIG_ADDR, '0, 32'h0BAD_0BAD, '0, 4'h1, '0, 1, '0, 1, g);
      xfer(0, 1, 0, 0, '0, CONFIG_ADDR, '0, '0, '0, '0, 0, 32'h0000_00C5, 0, g);

      // Reset during ACCESS: requester 0 owns the bus
      req_valid = 2'b01; req_write = 2'b00; req_addr = {32'h0, DATA_ADDR};
      @(posedge clock); @(negedge clock);
      req_valid = 2'b00;
      @(posedge clock); @(negedge clock);
      chk("pre_rst_access", 64'({psel, penable}), 64'(2'b11));
      reset = 1'b1;
      @(posedge clock); @(negedge clock);
      chk("rst_acc_bus", 64'({psel, penable}), 0);
      chk("rst_acc_rsp", 64'(rsp_valid), 0);
      reset = 1'b0;
      pready = 1'b1; prdata = 32'hFFFF_FFFF;
      @(posedge clock); @(negedge clock);
      chk("rst_acc_norsp", 64'(rsp_valid), 0);
      chk("rst_acc_idle",  64'(psel), 0);
      pready = 1'b0;
      last_g = 1'b1; prev_rd = '0; prev_err = 1'b0;
      xfer(1, 1, 0, 1, DATA_ADDR, CONFIG_ADDR, '0, 32'h5555_AAAA, '0, 4'hF, 1, 32'h7777_0000, 0, g);
      chk("rst_first_grant", 64'(g), 0);

      // Randomized traffic against the model
      for (int i = 0; i < 24; i++) begin
         bit v0, v1;
         v0 = 1'($urandom); v1 = 1'($urandom);
         if (!v0 && !v1) v0 = 1'b1;
         xfer(v0, v1, 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom,
              4'($urandom), 4'($urandom), $urandom_range(0, 3), $urandom,
              ($urandom_range(0, 7) == 0), g);
      end

`ifdef APB_ARB_TIMEOUT_EN
      // pready on the terminal count still completes normally
      xfer(1, 0, 0, 0, DATA_ADDR, '0, '0, '0, '0, '0, TO - 1, 32'h0F0F_0F0F, 0, g);
      // No pready: abort after TO ACCESS cycles
      req_valid = 2'b10; req_write = 2'b00; req_addr = {CONFIG_ADDR, 32'h0};
      #1;
      g = pick(0, 1);
      chk("to_ready", 64'(req_ready), 64'(2'b01 << g));
      last_g = g[0];
      @(posedge clock); @(negedge clock);
      req_valid = 2'b00; prdata = 32'hCAFE_F00D;
      @(posedge clock);
      for (int w = 0; w < TO; w++) begin
         @(negedge clock);
         chk("to_acc", 64'({psel, penable}), 64'(2'b11));
         chk("to_norsp", 64'(rsp_valid), 0);
         @(posedge clock);
      end
      @(negedge clock);
      chk("to_bus",   64'({psel, penable}), 0);
      chk("to_rspv",  64'(rsp_valid), 64'(2'b10));
      chk("to_err",   64'(rsp_err), 1);
      chk("to_rdata", 64'(rsp_rdata), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
